// File: rtl/e_mdu_pkg.sv
// Shared MD op codes, FSM state type and small helpers for the E-stage multiply/divide unit.
// The helper is_start_op honours `MDU_MADD_EN (multiply-accumulate ops).
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_MTHI  = 4'd4,
        MD_MTLO  = 4'd5,
        MD_MADD  = 4'd6,
        MD_MADDU = 4'd7,
        MD_MSUB  = 4'd8,
        MD_MSUBU = 4'd9
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Ops that open a busy window; accumulate ops only count when the feature is built in.
    function automatic logic is_start_op(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage MD unit request/result bundle: forwarded operands and op in, busy and HI/LO out.
interface e_mdu_if;
    logic        start;
    logic [3:0]  mdop;
    logic        hilo_we;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, mdop, hilo_we, in1, in2, input busy, hi, lo);
    modport slave  (input start, mdop, hilo_we, in1, in2, output busy, hi, lo);
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div into architectural HI/LO.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu accumulate ops.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    e_mdu_if.slave md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      p_hi_q, p_hi_d, p_lo_q, p_lo_d;

    logic [63:0] hilo, prod_s, prod_u, op_res;
    logic [31:0] a_mag, b_mag, div_b, quo_s, rem_s, quo_u, rem_u;
    logic        accept, is_div;

    // Result datapath: everything is computed from the operands present at the accept edge.
    always_comb begin
        hilo   = {hi_q, lo_q};
        prod_s = {{32{md.in1[31]}}, md.in1} * {{32{md.in2[31]}}, md.in2};
        prod_u = {32'd0, md.in1} * {32'd0, md.in2};
        // Sign-magnitude division keeps 0x80000000 / -1 well defined (quotient wraps).
        a_mag  = neg_if(md.in1[31], md.in1);
        b_mag  = (md.in2 == 32'd0) ? 32'd1 : neg_if(md.in2[31], md.in2);
        div_b  = (md.in2 == 32'd0) ? 32'd1 : md.in2;
        quo_s  = neg_if(md.in1[31] ^ md.in2[31], a_mag / b_mag);
        rem_s  = neg_if(md.in1[31], a_mag % b_mag);
        quo_u  = md.in1 / div_b;
        rem_u  = md.in1 % div_b;
        is_div = 1'b0;
        op_res = hilo;
        case (md.mdop)
            MD_MULT:  op_res = prod_s;
            MD_MULTU: op_res = prod_u;
            MD_DIV: begin
                is_div = 1'b1;
                if (md.in2 != 32'd0) op_res = {rem_s, quo_s};
            end
            MD_DIVU: begin
                is_div = 1'b1;
                if (md.in2 != 32'd0) op_res = {rem_u, quo_u};
            end
`ifdef MDU_MADD_EN
            MD_MADD:  op_res = hilo + prod_s;
            MD_MADDU: op_res = hilo + prod_u;
            MD_MSUB:  op_res = hilo - prod_s;
            MD_MSUBU: op_res = hilo - prod_u;
`endif
            default:  op_res = hilo;
        endcase
    end

    // Next-state: accept / mthi-mtlo while idle, count down and commit while busy.
    always_comb begin
        accept  = md.start && (state_q == ST_IDLE) && is_start_op(md.mdop);
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    p_hi_d  = op_res[63:32];
                    p_lo_d  = op_res[31:0];
                end else if (md.hilo_we && !md.start) begin
                    if (md.mdop == MD_MTHI) hi_d = md.in1;
                    if (md.mdop == MD_MTLO) lo_d = md.in1;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    hi_d    = p_hi_q;
                    lo_d    = p_lo_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
        end
    end

    assign md.busy = (state_q == ST_BUSY);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: vector table of mult/div ops plus hand sequences for
// mthi/mtlo, divide by zero, reset mid-op, ignored requests while busy and MDU_MADD_EN ops.
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    e_mdu_if md_if ();

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one start op, count its busy window (bounded) and check the committed HI/LO.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int cyc, input string tag);
        int n;
        @(negedge clk);
        md_if.start = 1'b1;
        md_if.mdop  = op;
        md_if.in1   = a;
        md_if.in2   = b;
        @(posedge clk);
        #1;
        md_if.start = 1'b0;
        n = 0;
        while (md_if.busy && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        check({tag, " busy_cycles"}, 32'(n), 32'(cyc));
        check({tag, " hi"}, md_if.hi, exp_hi);
        check({tag, " lo"}, md_if.lo, exp_lo);
        $display("[TB] %s op=%0d in1=0x%08h in2=0x%08h -> busy=%0d hi=0x%08h lo=0x%08h",
                 tag, op, a, b, n, md_if.hi, md_if.lo);
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] v);
        @(negedge clk);
        md_if.hilo_we = 1'b1;
        md_if.mdop    = op;
        md_if.in1     = v;
        @(posedge clk);
        #1;
        md_if.hilo_we = 1'b0;
        $display("[TB] move op=%0d val=0x%08h -> hi=0x%08h lo=0x%08h busy=%0b",
                 op, v, md_if.hi, md_if.lo, md_if.busy);
    endtask

    initial begin
        int n;

        vecs[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2] = '{MD_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 5};
        vecs[3] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[4] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[5] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[6] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7] = '{MD_DIVU,  32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 10};
        vecs[8] = '{MD_DIVU,  32'd5,        32'd0,        32'd5,        32'h19999999, 10};

        reset         = 1'b1;
        md_if.start   = 1'b0;
        md_if.hilo_we = 1'b0;
        md_if.mdop    = 4'd0;
        md_if.in1     = 32'd0;
        md_if.in2     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(md_if.busy), 32'd0);
        check("reset hi", md_if.hi, 32'd0);
        check("reset lo", md_if.lo, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                   vecs[i].cyc, $sformatf("vec%0d", i));
        end

        // mthi / mtlo while idle, then a divide by zero must preserve them.
        move_to(MD_MTHI, 32'h1234);
        check("mthi hi", md_if.hi, 32'h1234);
        check("mthi busy", 32'(md_if.busy), 32'd0);
        move_to(MD_MTLO, 32'h5678);
        check("mtlo lo", md_if.lo, 32'h5678);
        check("mtlo hi kept", md_if.hi, 32'h1234);
        run_op(MD_DIV, 32'd9, 32'd0, 32'h1234, 32'h5678, 10, "div0");

`ifdef MDU_MADD_EN
        move_to(MD_MTHI, 32'd0);
        move_to(MD_MTLO, 32'd10);
        run_op(MD_MADD,  32'd3,        32'd4,        32'h00000000, 32'd22,       5, "madd");
        run_op(MD_MSUB,  32'd2,        32'd20,       32'hFFFFFFFF, 32'hFFFFFFEE, 5, "msub");
        run_op(MD_MADDU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFEC, 5, "maddu");
        run_op(MD_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFEB, 5, "msubu");
`else
        run_op(MD_MADD,  32'd3, 32'd4, 32'h1234, 32'h5678, 0, "madd_noop");
        run_op(MD_MSUBU, 32'd3, 32'd4, 32'h1234, 32'h5678, 0, "msubu_noop");
`endif

        // Reset asserted in the third busy cycle aborts the op with no later commit.
        @(negedge clk);
        md_if.start = 1'b1;
        md_if.mdop  = MD_MULTU;
        md_if.in1   = 32'hFFFFFFFF;
        md_if.in2   = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        md_if.start = 1'b0;
        check("abort busy before reset", 32'(md_if.busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 32'(md_if.busy), 32'd0);
        check("abort hi", md_if.hi, 32'd0);
        check("abort lo", md_if.lo, 32'd0);
        repeat (12) @(negedge clk);
        check("abort late busy", 32'(md_if.busy), 32'd0);
        check("abort late hi", md_if.hi, 32'd0);
        check("abort late lo", md_if.lo, 32'd0);
        $display("[TB] abort multu -> busy=%0b hi=0x%08h lo=0x%08h", md_if.busy, md_if.hi, md_if.lo);

        // start(divu) and hilo_we(mtlo) during a mult are deliberate protocol violations; both must be ignored.
        @(negedge clk);
        md_if.start = 1'b1;
        md_if.mdop  = MD_MULT;
        md_if.in1   = 32'd6;
        md_if.in2   = 32'd7;
        @(posedge clk);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (md_if.busy) n++;
            case (i)
                0: begin
                    md_if.start = 1'b1;
                    md_if.mdop  = MD_DIVU;
                    md_if.in1   = 32'd100;
                    md_if.in2   = 32'd7;
                end
                1: begin
                    md_if.start   = 1'b0;
                    md_if.hilo_we = 1'b1;
                    md_if.mdop    = MD_MTLO;
                    md_if.in1     = 32'd99;
                end
                2: md_if.hilo_we = 1'b0;
                default: ;
            endcase
        end
        check("busy-ignore cycles", 32'(n), 32'd5);
        check("busy-ignore hi", md_if.hi, 32'd0);
        check("busy-ignore lo", md_if.lo, 32'd42);
        $display("[TB] mult 6*7 with ignored divu/mtlo -> busy=%0d hi=0x%08h lo=0x%08h",
                 n, md_if.hi, md_if.lo);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
